// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture decoder: segment patterns,
// FSM state type and the pattern-to-digit decode function.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h3F;
  localparam logic [6:0] SEG7_1     = 7'h06;
  localparam logic [6:0] SEG7_2     = 7'h5B;
  localparam logic [6:0] SEG7_3     = 7'h4F;
  localparam logic [6:0] SEG7_4     = 7'h66;
  localparam logic [6:0] SEG7_5     = 7'h6D;
  localparam logic [6:0] SEG7_6     = 7'h7D;
  localparam logic [6:0] SEG7_7     = 7'h07;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h6F;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Returns {legal, digit}; digit is 0 when the pattern is not a decimal digit.
  function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
    case (seg)
      SEG7_0:  seg7_decode = {1'b1, 4'd0};
      SEG7_1:  seg7_decode = {1'b1, 4'd1};
      SEG7_2:  seg7_decode = {1'b1, 4'd2};
      SEG7_3:  seg7_decode = {1'b1, 4'd3};
      SEG7_4:  seg7_decode = {1'b1, 4'd4};
      SEG7_5:  seg7_decode = {1'b1, 4'd5};
      SEG7_6:  seg7_decode = {1'b1, 4'd6};
      SEG7_7:  seg7_decode = {1'b1, 4'd7};
      SEG7_8:  seg7_decode = {1'b1, 4'd8};
      SEG7_9:  seg7_decode = {1'b1, 4'd9};
      default: seg7_decode = {1'b0, 4'd0};
    endcase
  endfunction

endpackage

// File: rtl/seg7_sync_debounce.sv
// Two-flop synchronizer for the {dp, seg} bus plus a saturating run-length
// counter of identical synchronized samples.
module seg7_sync_debounce #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] raw,
  output logic [7:0] sample,
  output logic       stable
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [7:0]    meta;
  logic [CW-1:0] cnt;

  // The counter tracks the sample being loaded this edge, so it reloads to 1 on a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 8'h00;
      sample <= 8'h00;
      cnt    <= '0;
    end else begin
      meta   <= raw;
      sample <= meta;
      if (meta != sample) begin
        cnt <= CW'(1);
      end else if (cnt != CMAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign stable = (cnt == CMAX);

endmodule

// File: rtl/seg7_capture_decoder.sv
// Debounced seven-segment capture and decode with change events and counters.
// Optional sequence checker enabled by defining SEG7_SEQ_CHECK_EN.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             dp_in,
  output logic [3:0]       digit_out,
  output logic             dp_out,
  output logic             digit_valid,
  output logic             blank,
  output logic             illegal,
  output logic [CNT_W-1:0] change_count,
  output logic             seq_err,
  output logic [7:0]       err_count
);

  logic [7:0] sample;
  logic       stable;

  seg7_sync_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .raw    ({dp_in, seg_in}),
    .sample (sample),
    .stable (stable)
  );

  state_t     state, state_next;
  logic [7:0] locked_pat, locked_pat_d;
  logic [7:0] last_pat, last_pat_d;
  logic       last_valid, last_valid_d;
  logic [4:0] dec;
  logic       eval, is_new, ev_legal, ev_blank, ev_illegal;

  logic [3:0]       digit_d;
  logic             dp_d, blank_d, valid_d, illegal_d;
  logic [CNT_W-1:0] count_d;

  always_ff @(posedge clk) begin
    if (reset) state <= SETTLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SETTLE:  if (stable) state_next = LOCKED;
      LOCKED:  if (sample != locked_pat) state_next = SETTLE;
      default: state_next = SETTLE;
    endcase
  end

  // An accepted pattern fires only if it differs from the last one; the reset
  // "none" state treats an all-zero bus as already seen.
  always_comb begin
    dec          = seg7_decode(sample[6:0]);
    eval         = (state == SETTLE) && stable;
    is_new       = eval && !((last_valid && (sample == last_pat)) ||
                             (!last_valid && (sample == 8'h00)));
    ev_blank     = is_new && (sample[6:0] == SEG7_BLANK);
    ev_legal     = is_new && dec[4];
    ev_illegal   = is_new && !dec[4] && !ev_blank;
    locked_pat_d = eval ? sample : locked_pat;
    last_pat_d   = is_new ? sample : last_pat;
    last_valid_d = last_valid || is_new;
    valid_d      = ev_legal;
    illegal_d    = ev_illegal;
    digit_d      = ev_legal ? dec[3:0] : digit_out;
    dp_d         = ev_legal ? sample[7] : dp_out;
    blank_d      = ev_blank ? 1'b1 : (ev_legal ? 1'b0 : blank);
    count_d      = ev_legal ? change_count + CNT_W'(1) : change_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked_pat   <= 8'h00;
      last_pat     <= 8'h00;
      last_valid   <= 1'b0;
      digit_out    <= 4'd0;
      dp_out       <= 1'b0;
      digit_valid  <= 1'b0;
      blank        <= 1'b0;
      illegal      <= 1'b0;
      change_count <= '0;
    end else begin
      locked_pat   <= locked_pat_d;
      last_pat     <= last_pat_d;
      last_valid   <= last_valid_d;
      digit_out    <= digit_d;
      dp_out       <= dp_d;
      digit_valid  <= valid_d;
      blank        <= blank_d;
      illegal      <= illegal_d;
      change_count <= count_d;
    end
  end

`ifdef SEG7_SEQ_CHECK_EN
  logic [3:0] prev_digit, expect_digit;
  logic       have_prev, seq_hit;

  // A repeated digit can only arrive through a dp-only change, which is allowed.
  always_comb begin
    expect_digit = (prev_digit == 4'd9) ? 4'd0 : prev_digit + 4'd1;
    seq_hit      = ev_legal && have_prev && (dec[3:0] != expect_digit) &&
                   (dec[3:0] != prev_digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_digit <= 4'd0;
      have_prev  <= 1'b0;
      seq_err    <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      seq_err <= seq_hit;
      if (seq_hit && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (ev_legal) begin
        prev_digit <= dec[3:0];
        have_prev  <= 1'b1;
      end else if (ev_blank || ev_illegal) begin
        have_prev <= 1'b0;
      end
    end
  end
`else
  assign seq_err   = 1'b0;
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Scoreboard bench for seg7_capture_decoder: directed patterns push expected
// events, a negedge monitor pops and compares on every output event.
module tb_seg7_capture_decoder;

`ifdef SEG7_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic       clk, reset;
  logic [6:0] seg_in;
  logic       dp_in;
  logic [3:0] digit_out;
  logic       dp_out, digit_valid, blank, illegal, seq_err;
  logic [7:0] change_count, err_count;

  seg7_capture_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_in       (seg_in),
    .dp_in        (dp_in),
    .digit_out    (digit_out),
    .dp_out       (dp_out),
    .digit_valid  (digit_valid),
    .blank        (blank),
    .illegal      (illegal),
    .change_count (change_count),
    .seq_err      (seq_err),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 digit_valid, 1 illegal, 2 blank
    int digit;
    int dp;
    int blk;
    int cnt;
    int seq;
    int errc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic blank_q = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every pulse or blank rising edge is one event to match.
  always @(negedge clk) begin
    if (digit_valid || illegal || seq_err || (blank && !blank_q)) begin
      chk("excl_valid_illegal", int'(digit_valid & illegal), 0);
      chk("excl_seq_illegal", int'(seq_err & illegal), 0);
      if (q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("kind", digit_valid ? 0 : (illegal ? 1 : 2), e.kind);
        chk("digit_out", int'(digit_out), e.digit);
        chk("dp_out", int'(dp_out), e.dp);
        chk("blank", int'(blank), e.blk);
        chk("change_count", int'(change_count), e.cnt);
        chk("seq_err", int'(seq_err), e.seq);
        chk("err_count", int'(err_count), e.errc);
      end
    end
    blank_q = blank;
  end

  task automatic push(input int kind, input int digit, input int dpv, input int blk,
                      input int cnt, input int seqh, input int errh);
    exp_t e;
    e.kind  = kind;
    e.digit = digit;
    e.dp    = dpv;
    e.blk   = blk;
    e.cnt   = cnt;
    e.seq   = SEQ_EN ? seqh : 0;
    e.errc  = SEQ_EN ? errh : 0;
    q.push_back(e);
  endtask

  task automatic drive(input logic [6:0] s, input logic d, input int hold);
    @(negedge clk);
    seg_in = s;
    dp_in  = d;
    repeat (hold) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_digit_out"}, int'(digit_out), 0);
    chk({tag, "_dp_out"}, int'(dp_out), 0);
    chk({tag, "_digit_valid"}, int'(digit_valid), 0);
    chk({tag, "_blank"}, int'(blank), 0);
    chk({tag, "_illegal"}, int'(illegal), 0);
    chk({tag, "_change_count"}, int'(change_count), 0);
    chk({tag, "_seq_err"}, int'(seq_err), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    seg_in = 7'h00;
    dp_in  = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero(tag);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int n;
    int cnt;
    reset  = 1'b1;
    seg_in = 7'h00;
    dp_in  = 1'b0;
    do_reset("reset");

    // 3F after reset: one digit_valid exactly 6 edges after the input change.
    push(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    seg_in = 7'h3F;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (digit_valid) break;
    end
    chk("latency", n, 6);
    repeat (10) @(negedge clk);

    // Two-cycle glitch of 06 inside held 3F: nothing.
    drive(7'h06, 1'b0, 2);
    drive(7'h3F, 1'b0, 20);

    // Illegal pattern: digit stays 0, count stays 1.
    push(1, 0, 0, 0, 1, 0, 0);
    drive(7'h12, 1'b0, 20);

    // Counting sequence from a fresh reset.
    do_reset("reset2");
    push(0, 0, 0, 0, 1, 0, 0); drive(7'h3F, 1'b0, 20);
    push(0, 1, 0, 0, 2, 0, 0); drive(7'h06, 1'b0, 20);
    push(0, 2, 0, 0, 3, 0, 0); drive(7'h5B, 1'b0, 20);
    push(0, 3, 0, 0, 4, 0, 0); drive(7'h4F, 1'b0, 20);

    // Blank, skipped digit, re-arm after blank, dp-only repeat, out-of-order digit.
    push(2, 3, 0, 1, 4, 0, 0);  drive(7'h00, 1'b0, 20);
    push(0, 0, 0, 0, 5, 0, 0);  drive(7'h3F, 1'b0, 20);
    push(0, 1, 0, 0, 6, 0, 0);  drive(7'h06, 1'b0, 20);
    push(0, 4, 0, 0, 7, 1, 1);  drive(7'h66, 1'b0, 20);
    push(2, 4, 0, 1, 7, 0, 1);  drive(7'h00, 1'b0, 20);
    push(0, 2, 0, 0, 8, 0, 1);  drive(7'h5B, 1'b0, 20);
    push(0, 2, 1, 0, 9, 0, 1);  drive(7'h5B, 1'b1, 20);
    push(0, 3, 1, 0, 10, 0, 1); drive(7'h4F, 1'b1, 20);
    push(0, 9, 0, 0, 11, 1, 2); drive(7'h6F, 1'b0, 20);

    // dp toggles on 0 until change_count wraps past 255.
    cnt = 11;
    for (int i = 0; i < 250; i++) begin
      cnt = (cnt + 1) % 256;
      push(0, 0, i % 2, 0, cnt, 0, 2);
      drive(7'h3F, 1'(i % 2), 8);
    end
    chk("wrapped_count", int'(change_count), 5);

    // Reset in the middle of settling a new pattern.
    drive(7'h06, 1'b0, 3);
    seg_in = 7'h00;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("after_reset_blank", int'(blank), 0);
    chk("after_reset_count", int'(change_count), 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
